// File: rtl/video_refresh_sequencer.sv
// Purpose : drives the video address counter control pins (ST, LD_n, CT_n, CI_n, UP_n, OE)
//           and generates HSYNC_n/VSYNC_n/BLANK_n and the vertical-retrace interrupt VINT.
// Latency : every output is registered and reflects the counter state of the previous CLK.
// Backpressure: none; free-running raster timing. SCROLL_REQ is latched until the next frame edge.
// Ports   : CLK, RESET_n (sync, active low), SCROLL_REQ, VINT_ACK in; counter controls,
//           syncs, BLANK_n and VINT out.
module video_refresh_sequencer #(
    parameter int WORD_DIV = 16,
    parameter int H_ACTIVE = 72,
    parameter int H_TOTAL  = 92,
    parameter int HS_START = 76,
    parameter int HS_WIDTH = 8,
    parameter int V_ACTIVE = 900,
    parameter int V_TOTAL  = 937,
    parameter int VS_START = 903,
    parameter int VS_WIDTH = 4
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic SCROLL_REQ,
    input  logic VINT_ACK,
    output logic ST,
    output logic LD_n,
    output logic CT_n,
    output logic CI_n,
    output logic UP_n,
    output logic OE,
    output logic HSYNC_n,
    output logic VSYNC_n,
    output logic BLANK_n,
    output logic VINT
);

    // One spare bit on h/v so the sync end indices always fit.
    localparam int PW = (WORD_DIV > 1) ? $clog2(WORD_DIV) : 1;
    localparam int HW = $clog2(H_TOTAL) + 1;
    localparam int VW = $clog2(V_TOTAL) + 1;

    localparam logic [PW-1:0] PIX_LAST = PW'(WORD_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(HS_START);
    localparam logic [HW-1:0] HS_END   = HW'(HS_START + HS_WIDTH);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_M1 = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG   = VW'(VS_START);
    localparam logic [VW-1:0] VS_END   = VW'(VS_START + VS_WIDTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t        state;
    logic [PW-1:0] pix_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          scroll_pend;

    logic word_tick, line_end, frame_edge, active, vint_set;

    assign word_tick  = (pix_cnt == PIX_LAST);
    assign line_end   = word_tick && (h_cnt == H_LAST);
    assign frame_edge = line_end && (v_cnt == V_LAST);
    assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    // The edge on which v_cnt steps into the first blank line.
    assign vint_set   = line_end && (v_cnt == V_ACT_M1);

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state       <= INIT;
            pix_cnt     <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            scroll_pend <= 1'b0;
            ST          <= 1'b0;
            LD_n        <= 1'b1;
            CT_n        <= 1'b1;
            CI_n        <= 1'b1;
            UP_n        <= 1'b1;
            OE          <= 1'b1;
            HSYNC_n     <= 1'b1;
            VSYNC_n     <= 1'b1;
            BLANK_n     <= 1'b0;
            VINT        <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    // Preset the address counter to all ones and enable it; the
                    // first counted word then wraps it to address 0.
                    state       <= RUN;
                    pix_cnt     <= '0;
                    h_cnt       <= '0;
                    v_cnt       <= '0;
                    ST          <= 1'b1;
                    LD_n        <= 1'b1;
                    CT_n        <= 1'b1;
                    CI_n        <= 1'b0;
                    UP_n        <= 1'b0;
                    OE          <= 1'b0;
                    HSYNC_n     <= 1'b1;
                    VSYNC_n     <= 1'b1;
                    BLANK_n     <= 1'b0;
                    scroll_pend <= scroll_pend | SCROLL_REQ;
                    if (VINT_ACK) begin
                        VINT <= 1'b0;
                    end
                end
                RUN: begin
                    if (word_tick) begin
                        pix_cnt <= '0;
                        if (h_cnt == H_LAST) begin
                            h_cnt <= '0;
                            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
                        end else begin
                            h_cnt <= h_cnt + HW'(1);
                        end
                    end else begin
                        pix_cnt <= pix_cnt + PW'(1);
                    end

                    CI_n    <= 1'b0;
                    UP_n    <= 1'b0;
                    OE      <= 1'b0;
                    CT_n    <= ~(word_tick && active);
                    BLANK_n <= active;
                    HSYNC_n <= ~((h_cnt >= HS_BEG) && (h_cnt < HS_END));
                    VSYNC_n <= ~((v_cnt >= VS_BEG) && (v_cnt < VS_END));

                    // frame_edge is the last pixel of a blank line, so the
                    // preset/load never coincides with a count cycle.
                    ST   <= frame_edge && !scroll_pend;
                    LD_n <= ~(frame_edge && scroll_pend);

                    // A request landing on the frame edge is kept for the next frame.
                    if (frame_edge) begin
                        scroll_pend <= SCROLL_REQ;
                    end else if (SCROLL_REQ) begin
                        scroll_pend <= 1'b1;
                    end

                    if (vint_set) begin
                        VINT <= 1'b1;
                    end else if (VINT_ACK) begin
                        VINT <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_video_refresh_sequencer.sv
module tb_video_refresh_sequencer;

    localparam int WD  = 2;
    localparam int HA  = 4;
    localparam int HT  = 6;
    localparam int HSS = 4;
    localparam int HSW = 1;
    localparam int VA  = 3;
    localparam int VT  = 5;
    localparam int VSS = 3;
    localparam int VSW = 1;

    // {ST, LD_n, CT_n, CI_n, UP_n, OE, HSYNC_n, VSYNC_n, BLANK_n, VINT}
    localparam logic [9:0] RST_VALS  = 10'b0111111100;
    localparam logic [9:0] INIT_VALS = 10'b1110001100;

    logic CLK = 1'b0;
    logic RESET_n = 1'b0;
    logic SCROLL_REQ = 1'b0;
    logic VINT_ACK = 1'b0;
    logic ST, LD_n, CT_n, CI_n, UP_n, OE, HSYNC_n, VSYNC_n, BLANK_n, VINT;
    logic [9:0] obs;

    assign obs = {ST, LD_n, CT_n, CI_n, UP_n, OE, HSYNC_n, VSYNC_n, BLANK_n, VINT};

    always #5 CLK = ~CLK;

    video_refresh_sequencer #(
        .WORD_DIV(WD), .H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HSS), .HS_WIDTH(HSW),
        .V_ACTIVE(VA), .V_TOTAL(VT), .VS_START(VSS), .VS_WIDTH(VSW)
    ) dut (
        .CLK(CLK), .RESET_n(RESET_n), .SCROLL_REQ(SCROLL_REQ), .VINT_ACK(VINT_ACK),
        .ST(ST), .LD_n(LD_n), .CT_n(CT_n), .CI_n(CI_n), .UP_n(UP_n), .OE(OE),
        .HSYNC_n(HSYNC_n), .VSYNC_n(VSYNC_n), .BLANK_n(BLANK_n), .VINT(VINT)
    );

    typedef struct {
        logic       rst_n;
        logic       sreq;
        logic       ack;
        logic [9:0] exp;
    } vec_t;

    vec_t       tbl [7];
    logic [9:0] sb_q [$];
    int         checks = 0;
    int         failures = 0;

    // Reference state: edges since reset release (0 = INIT edge).
    int   mk = 0;
    int   last_k = -1;
    logic m_pend = 1'b0;
    logic m_vint = 1'b0;

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%b exp=%b", name, last_k, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step(input string name, input logic rst, input logic sreq, input logic ack,
                        input logic use_tbl, input logic [9:0] texp);
        logic [9:0] e;
        int p, pix, h, v;
        logic wt, fe, st, ld_n, ct_n, hs_n, vs_n, bl;
        if (!rst) begin
            e      = RST_VALS;
            mk     = 0;
            last_k = -1;
            m_pend = 1'b0;
            m_vint = 1'b0;
        end else if (mk == 0) begin
            if (ack) m_vint = 1'b0;
            m_pend = m_pend | sreq;
            e      = {INIT_VALS[9:1], m_vint};
            last_k = 0;
            mk     = 1;
        end else begin
            p    = mk - 1;
            pix  = p % WD;
            h    = (p / WD) % HT;
            v    = (p / (WD * HT)) % VT;
            wt   = (pix == WD - 1);
            fe   = wt && (h == HT - 1) && (v == VT - 1);
            ct_n = !(wt && h < HA && v < VA);
            bl   = (h < HA) && (v < VA);
            hs_n = !(h >= HSS && h < HSS + HSW);
            vs_n = !(v >= VSS && v < VSS + VSW);
            st   = fe && !m_pend;
            ld_n = !(fe && m_pend);
            m_pend = fe ? sreq : (m_pend | sreq);
            if (wt && h == HT - 1 && v == VA - 1) m_vint = 1'b1;
            else if (ack) m_vint = 1'b0;
            e      = {st, ld_n, ct_n, 3'b000, hs_n, vs_n, bl, m_vint};
            last_k = mk;
            mk     = mk + 1;
        end
        RESET_n    = rst;
        SCROLL_REQ = sreq;
        VINT_ACK   = ack;
        sb_q.push_back(use_tbl ? texp : e);
        @(posedge CLK);
        #1;
        check(name, obs, sb_q.pop_front());
    endtask

    int ct_lows = 0, st_pulses = 0, ld_pulses = 0, bl_hi = 0, hs_lows = 0, vs_lows = 0;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, RST_VALS};
        tbl[1] = '{1'b0, 1'b0, 1'b0, RST_VALS};
        tbl[2] = '{1'b1, 1'b0, 1'b0, INIT_VALS};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 10'b0110001110};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 10'b0100001110};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 10'b0110001110};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 10'b0100001110};

        @(negedge CLK);
        for (int i = 0; i < 7; i++) begin
            step("vec", tbl[i].rst_n, tbl[i].sreq, tbl[i].ack, 1'b1, tbl[i].exp);
        end

        // Free run through three frames with a scroll request and VINT acks.
        while (last_k < 254) begin
            step("run", 1'b1, mk == 133, (mk == 160) || (mk == 216) || (mk == 220), 1'b0, 10'd0);
            if (last_k >= 61 && last_k <= 120) begin
                if (!CT_n)    ct_lows++;
                if (ST)       st_pulses++;
                if (!LD_n)    ld_pulses++;
                if (BLANK_n)  bl_hi++;
                if (!HSYNC_n) hs_lows++;
                if (!VSYNC_n) vs_lows++;
            end
            if (last_k == 36)  check("vint_rise", {9'd0, VINT}, 10'd1);
            if (last_k == 160) check("vint_ack_clear", {9'd0, VINT}, 10'd0);
            if (last_k == 216) check("vint_set_wins", {9'd0, VINT}, 10'd1);
            if (last_k == 180) check("scroll_load", {8'd0, ST, LD_n}, 10'b00);
            if (last_k == 240) check("st_revert", {8'd0, ST, LD_n}, 10'b11);
        end
        check_int("frame_ct_lows", ct_lows, HA * VA);
        check_int("frame_st_pulses", st_pulses, 1);
        check_int("frame_ld_pulses", ld_pulses, 0);
        check_int("frame_blank_hi", bl_hi, HA * VA * WD);
        check_int("frame_hsync_lows", hs_lows, HSW * WD * VT);
        check_int("frame_vsync_lows", vs_lows, VSW * WD * HT);

        // Reset in the middle of line 1, then restart.
        step("mid_reset", 1'b0, 1'b0, 1'b0, 1'b1, RST_VALS);
        step("init_again", 1'b1, 1'b0, 1'b0, 1'b1, INIT_VALS);
        while (last_k < 70) begin
            step("rerun", 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
            if (last_k == 1) check("restart_no_count", {9'd0, CT_n}, 10'd1);
            if (last_k == 2) check("restart_first_count", {9'd0, CT_n}, 10'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_refresh_sequencer.md
Name: video_refresh_sequencer

Overview:
- Timing sequencer that drives the control pins of the 10-bit video refresh address counter (ST, LD_n, CT_n, CI_n, UP_n, OE).
- Also generates raster sync, blanking and the vertical-retrace interrupt.
- Sits directly upstream of the counter on the video board.
- Advances the counter exactly once per displayed 16-pixel word; presets or loads it once per frame during vertical blank.

Parameters:
- WORD_DIV, 16: CLK cycles per video word; must be >= 2.
- H_ACTIVE, 72: displayed words per line.
- H_TOTAL, 92: total words per line; must be > H_ACTIVE.
- HS_START, 76: word index where HSYNC_n falls.
- HS_WIDTH, 8: HSYNC_n low width, in words.
- V_ACTIVE, 900: displayed lines per frame.
- V_TOTAL, 937: total lines per frame; must be > V_ACTIVE.
- VS_START, 903: line index where VSYNC_n falls.
- VS_WIDTH, 4: VSYNC_n low width, in lines.

Ports:
- CLK, input, 1: pixel clock. All state changes on posedge.
- RESET_n, input, 1: synchronous, active-low reset, sampled on posedge CLK.
- SCROLL_REQ, input, 1: one-cycle request to load the counter from its D inputs at the next frame start.
- VINT_ACK, input, 1: clears VINT.
- ST, output, 1: counter preset-to-all-ones strobe.
- LD_n, output, 1: counter parallel-load strobe, active low.
- CT_n, output, 1: counter count enable, active low.
- CI_n, output, 1: counter carry-in, active low.
- UP_n, output, 1: counter direction, 0 = up.
- OE, output, 1: counter output enable, 1 = outputs tri-stated.
- HSYNC_n, output, 1: horizontal sync.
- VSYNC_n, output, 1: vertical sync.
- BLANK_n, output, 1: 1 = display active.
- VINT, output, 1: vertical-retrace interrupt, level.

Behaviour:
Reset
- Applies while RESET_n is 0 at posedge CLK; also valid mid-frame.
- All counters clear to 0; FSM enters INIT.
- Output values: ST=0, LD_n=1, CT_n=1, CI_n=1, UP_n=1, OE=1, HSYNC_n=1, VSYNC_n=1, BLANK_n=0, VINT=0.
- Pending scroll request is discarded.

Counters
- pix_cnt runs 0..WORD_DIV-1. word_tick = (pix_cnt == WORD_DIV-1).
- h_cnt runs 0..H_TOTAL-1 and increments on word_tick.
- v_cnt increments when h_cnt wraps; v_cnt wraps V_TOTAL-1 -> 0.
- frame_edge = word_tick && h_cnt == H_TOTAL-1 && v_cnt == V_TOTAL-1.

FSM (INIT, RUN)
- INIT lasts exactly one cycle:
  - ST=1, UP_n=0, CI_n=0, OE=0 registered.
  - Next state RUN; counters restart at 0.
- RUN: all outputs below are registered, so each is valid the cycle after the condition it decodes.
  - CT_n = ~(word_tick && h_cnt < H_ACTIVE && v_cnt < V_ACTIVE). Result: exactly one CT_n-low cycle per active word, and H_ACTIVE*V_ACTIVE counts per frame.
  - BLANK_n = (h_cnt < H_ACTIVE && v_cnt < V_ACTIVE).
  - HSYNC_n = 0 for HS_START <= h_cnt < HS_START+HS_WIDTH.
  - VSYNC_n = 0 for VS_START <= v_cnt < VS_START+VS_WIDTH.
- At frame_edge:
  - If scroll_pend: LD_n=0 for one cycle and scroll_pend clears.
  - Otherwise: ST=1 for one cycle.
  - The two are never asserted together.
- ST, LD_n and CT_n are never simultaneously active. The ST/LD_n cycle falls in blanking; the first active word of the next frame counts from the preset/loaded value, so after ST the first address is 0.
- SCROLL_REQ sets scroll_pend. A request on the frame_edge cycle itself applies to the following frame.
- VINT sets on the posedge where v_cnt becomes V_ACTIVE (h_cnt=0, word_tick). VINT_ACK clears it; if set and ack occur in the same cycle, set wins.
- UP_n=0, CI_n=0 and OE=0 remain constant in RUN.

Test Plan:
1. Release reset with WORD_DIV=2, H_ACTIVE=4, H_TOTAL=6, V_ACTIVE=3, V_TOTAL=5 -> one ST pulse in the INIT cycle; OE, UP_n and CI_n go 0 the same cycle; first CT_n low 2 cycles later.
2. Same config, one full frame (60 CLK) -> exactly 12 CT_n-low cycles, each 2 CLK apart within a line; one ST pulse at frame_edge; BLANK_n high for 8 CLK per active line.
3. SCROLL_REQ pulsed at line 1 -> next frame_edge shows LD_n=0 and ST=0; the frame after reverts to ST=1.
4. HS_START=4, HS_WIDTH=1, VS_START=3, VS_WIDTH=1 -> HSYNC_n low 2 CLK per line at word 4; VSYNC_n low for exactly line 3 (12 CLK).
5. VINT rises at line 3 start; VINT_ACK asserted same cycle as the next set -> VINT stays 1; ack alone -> VINT 0 the next cycle.
6. RESET_n low mid-line 1 -> next cycle all outputs at reset values; after release, INIT ST pulse occurs and the count sequence restarts from h=0, v=0.
